zbt_sram_ctrl_pipe: RTL
=======================

// Module: zbt_sram_ctrl_pipe
// PURPOSE
//  Parametrised pipelined controller for a ZBT/NoBL synchronous SRAM.
//  Accepts one read or write per cycle, tags each read and returns read
//  data through a response FIFO with ready/valid backpressure.
//  Read issue is credit-limited, so no response is ever dropped.
//  Sits between the application/arbiter and the board SRAM pins.
// PARAMETERS
//  ADDR_W      18   SRAM word address width
//  DATA_W      32   data width; must be a multiple of 8
//  BYTES       DATA_W/8  byte lanes; derived, not overridable
//  RD_LAT      2    SRAM pipeline depth: cycles from address at pins to data at pins (1..4)
//  RESP_DEPTH  4    response FIFO entries, power of 2, >= RD_LAT+2
//  TAG_W       4    request tag width
// PORTS
//  clock          in    1        system clock; also forwarded as sram_clk
//  reset_n        in    1        asynchronous active-low reset
//  addr_valid     in    1        request valid
//  ready          out   1        request accepted when addr_valid & ready
//  addr           in    ADDR_W   word address
//  data_in        in    DATA_W   write data
//  write_mask     in    BYTES    byte enables; nonzero=write, zero=read
//  tag_in         in    TAG_W    tag, returned with read data
//  resp_valid     out   1        read response valid
//  resp_ready     in    1        response consumed when resp_valid & resp_ready
//  resp_data      out   DATA_W   read data
//  resp_tag       out   TAG_W    tag of the read
//  sram_clk       out   1        = clock
//  sram_cs_l, sram_mode, sram_adv_ld_l, sram_oe_l  out 1  tied 0
//  sram_we_l      out   1        registered, low on write cycles
//  sram_bw_l      out   BYTES    registered active-low byte writes
//  sram_addr      out   ADDR_W   registered address
//  sram_data      inout DATA_W   bidirectional data pins
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - sram_bw_l = all 1, sram_we_l = 1, sram_addr = 0, sram_data = Z.
//   - resp_valid = 0, FIFO empty, in-flight pipeline cleared.
//   - ready = 0 while in reset; ready = 1 on the first cycle after release.
//  Issue: accept at edge E0. After E0, sram_addr/bw_l/we_l hold the request.
//   Idle cycles drive bw_l = all 1, we_l = 1, addr unchanged.
//  Write: data_in is carried through a shift pipe and driven on sram_data
//   during cycle E0+1+RD_LAT only. sram_data is Z in every other cycle.
//   A write produces no response.
//  Read:
//   - Pin data is sampled at the edge closing cycle E0+1+RD_LAT.
//   - It is pushed with its tag into the FIFO one edge later.
//   - resp_valid rises RD_LAT+3 cycles after E0 (5 for RD_LAT=2) if the FIFO was empty.
//  Back-to-back issue: any R/W mix at full rate, no bubbles (ZBT).
//   Order of responses = order of read acceptance.
//  Credits:
//   - outstanding = reads in pipe + FIFO count.
//   - ready = (outstanding < RESP_DEPTH); writes are gated by the same ready.
//   - outstanding += 1 on accepting a read; -= 1 on pop; both in one cycle -> unchanged.
//   - ready is combinational from the registered counter. A same-cycle pop
//     does not raise ready until the next cycle.
//  FIFO: show-ahead; resp_data/resp_tag are stable while resp_valid & !resp_ready.
//   Overflow is impossible by construction; the bench asserts on it.
//  Reset mid-operation:
//   - In-flight reads are discarded and the FIFO is flushed.
//   - A write in flight may be truncated; sram_data goes Z immediately.
//  Widths: counter is clog2(RESP_DEPTH)+1 bits; FIFO pointers wrap modulo RESP_DEPTH.
// TESTING
//  1 Write A=0x00010 D=0xDEADBEEF mask=F, then read A tag=3.
//    -> resp_data=0xDEADBEEF, tag=3, resp_valid 5 cycles after read accept.
//  2 Write 0x11223344, then write 0xAAAAAAAA mask=0x2, then read.
//    -> 0x1122AA44; sram_we_l low exactly 2 cycles.
//  3 8 reads back-to-back, resp_ready=0.
//    -> ready drops after 4 accepts; resp holds 1st data.
//    -> Release resp_ready: 8 responses in order, tags 0..7.
//  4 Alternating W/R each cycle to 4 addresses.
//    -> no idle cycles; sram_data driven only in write slots; reads return prior writes.
//  5 Assert reset_n=0 with 3 reads in flight.
//    -> resp_valid=0, sram_data=Z, bw_l=F asynchronously.
//    -> After release: ready=1, no stale response appears.
//  6 RD_LAT=3, RESP_DEPTH=8, DATA_W=64 (BYTES=8): repeat 1 and 3.
//    -> latency 6; ready drops after 8 reads.

Source files
------------

// File: rtl/zbt_sram_ctrl_pipe.sv
// Pipelined ZBT/NoBL SRAM controller: one read or write per cycle, tagged read
// responses returned through a credit-limited show-ahead FIFO.
module zbt_sram_ctrl_pipe #(
    parameter  int ADDR_W     = 18,
    parameter  int DATA_W     = 32,
    parameter  int RD_LAT     = 2,
    parameter  int RESP_DEPTH = 4,
    parameter  int TAG_W      = 4,
    localparam int BYTES      = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              addr_valid,
    output logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [BYTES-1:0]  write_mask,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              sram_clk,
    output logic              sram_cs_l,
    output logic              sram_mode,
    output logic              sram_adv_ld_l,
    output logic              sram_oe_l,
    output logic              sram_we_l,
    output logic [BYTES-1:0]  sram_bw_l,
    output logic [ADDR_W-1:0] sram_addr,
    inout  logic [DATA_W-1:0] sram_data
);
    // Stage LAST holds the request whose data phase is on the pins this cycle.
    localparam int unsigned LAST = RD_LAT + 1;
    localparam int          CW   = $clog2(RESP_DEPTH) + 1;
    localparam int          PW   = $clog2(RESP_DEPTH);

    logic              accept;
    logic              is_wr;
    logic              rd_accept;
    logic              pop;
    logic [LAST:0]     p_rd;
    logic [LAST:0]     p_wr;
    logic [DATA_W-1:0] p_data [LAST+1];
    logic [TAG_W-1:0]  p_tag  [LAST+1];
    logic              cap_vld;
    logic [DATA_W-1:0] cap_data;
    logic [TAG_W-1:0]  cap_tag;
    logic [CW-1:0]     out_cnt;
    logic [CW-1:0]     fifo_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W+TAG_W-1:0] fifo_mem [RESP_DEPTH];

    assign sram_clk      = clock;
    assign sram_cs_l     = 1'b0;
    assign sram_mode     = 1'b0;
    assign sram_adv_ld_l = 1'b0;
    assign sram_oe_l     = 1'b0;

    assign is_wr     = |write_mask;
    assign ready     = reset_n && (out_cnt < CW'(RESP_DEPTH));
    assign accept    = addr_valid && ready;
    assign rd_accept = accept && !is_wr;
    assign pop       = resp_valid && resp_ready;

    assign resp_valid            = (fifo_cnt != '0);
    assign {resp_data, resp_tag} = fifo_mem[rd_ptr];

    // Pins are released as soon as reset asserts because p_wr clears asynchronously.
    assign sram_data = p_wr[LAST] ? p_data[LAST] : 'z;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sram_we_l <= 1'b1;
            sram_bw_l <= '1;
            sram_addr <= '0;
        end else if (accept) begin
            sram_we_l <= !is_wr;
            sram_bw_l <= ~write_mask;
            sram_addr <= addr;
        end else begin
            sram_we_l <= 1'b1;
            sram_bw_l <= '1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_rd    <= '0;
            p_wr    <= '0;
            cap_vld <= 1'b0;
        end else begin
            p_rd    <= {p_rd[LAST-1:0], rd_accept};
            p_wr    <= {p_wr[LAST-1:0], accept && is_wr};
            cap_vld <= p_rd[LAST];
        end
    end

    always_ff @(posedge clock) begin
        p_data[0] <= data_in;
        p_tag[0]  <= tag_in;
        for (int unsigned i = 1; i <= LAST; i++) begin
            p_data[i] <= p_data[i-1];
            p_tag[i]  <= p_tag[i-1];
        end
        cap_data <= sram_data;
        cap_tag  <= p_tag[LAST];
        if (cap_vld) begin
            fifo_mem[wr_ptr] <= {cap_data, cap_tag};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt  <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            out_cnt  <= out_cnt + CW'(rd_accept) - CW'(pop);
            fifo_cnt <= fifo_cnt + CW'(cap_vld) - CW'(pop);
            if (cap_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule
